// File: rtl/hiscore_dumper_if.sv
// rtl/hiscore_dumper_if.sv - HPS ioctl upload bus and game RAM read port for hiscore_dumper
interface hiscore_dumper_if #(
   parameter int RAM_AW = 12
);
   logic              ioctl_upload;
   logic              ioctl_rd;
   logic [24:0]       ioctl_addr;
   logic [7:0]        ioctl_din;
   logic [RAM_AW-1:0] ram_address;
   logic [7:0]        ram_data;
   logic              ram_read;

   modport master (
      output ioctl_upload, ioctl_rd, ioctl_addr, ram_data,
      input  ioctl_din, ram_address, ram_read
   );

   modport slave (
      input  ioctl_upload, ioctl_rd, ioctl_addr, ram_data,
      output ioctl_din, ram_address, ram_read
   );
endinterface

// File: rtl/hiscore_dumper.sv
// rtl/hiscore_dumper.sv - hiscore region upload server and autosave change scanner
// Optional pause-acknowledge timeout enabled by defining HS_DUMP_TIMEOUT_EN.
module hiscore_dumper #(
   parameter int                RAM_AW      = 12,
   parameter logic [RAM_AW-1:0] REGION_BASE = '0,
   parameter int                REGION_LEN  = 64,
   parameter int                SCAN_FRAMES = 60
`ifdef HS_DUMP_TIMEOUT_EN
   ,
   parameter int                TIMEOUT     = 65535
`endif
) (
   input  logic             clk,
   input  logic             reset_n,
   hiscore_dumper_if.slave  bus,
   input  logic             paused,
   output logic             pause_req,
   input  logic             autosave,
   input  logic             vblank,
   output logic             upload_req,
   output logic             busy
);
   localparam int                FW         = (SCAN_FRAMES > 1) ? $clog2(SCAN_FRAMES) : 1;
   localparam logic [FW-1:0]     FRAME_LAST = FW'(SCAN_FRAMES - 1);
   localparam logic [RAM_AW-1:0] IDX_LAST   = RAM_AW'(REGION_LEN - 1);
   localparam logic [24:0]       LEN25      = 25'(REGION_LEN);

   typedef enum logic [3:0] {
      IDLE, UP_PAUSE, UP_WAIT, UP_FETCH, UP_LATCH,
      SC_PAUSE, SC_READ, SC_ACC, SC_CMP
   } state_t;

   state_t            state;
   logic              upload_q, vblank_q;
   logic [FW-1:0]     frame_cnt;
   logic              scan_pend;
   logic [RAM_AW-1:0] idx;
   logic [15:0]       sum, baseline;
   logic              baseline_valid;
   logic [7:0]        din_q;
   logic [RAM_AW-1:0] addr_q;
   logic              ram_read_q, pause_req_q, upload_req_q;

   logic        upload_rise, vblank_rise, frame_hit, scan_due, scan_start;
   logic        in_upload, in_scan, rd_in_region;
   logic [15:0] sum_next;

`ifdef HS_DUMP_TIMEOUT_EN
   logic [15:0] to_cnt;
   logic        no_ram;
   logic        to_hit;
   assign to_hit       = (to_cnt == 16'(TIMEOUT - 1));
   assign rd_in_region = (bus.ioctl_addr < LEN25) && !no_ram;
`else
   assign rd_in_region = (bus.ioctl_addr < LEN25);
`endif

   assign upload_rise = bus.ioctl_upload & ~upload_q;
   assign vblank_rise = vblank & ~vblank_q;
   assign frame_hit   = vblank_rise && (frame_cnt == FRAME_LAST);
   assign scan_due    = autosave && (scan_pend || frame_hit);
   // An upload rise on the trigger clock wins; the scan stays pending.
   assign scan_start  = scan_due && (state == IDLE) && !upload_rise;
   assign in_upload   = state inside {UP_PAUSE, UP_WAIT, UP_FETCH, UP_LATCH};
   assign in_scan     = state inside {SC_PAUSE, SC_READ, SC_ACC, SC_CMP};
   assign sum_next    = {sum[14:0], sum[15]} + {8'h00, bus.ram_data};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state          <= IDLE;
         upload_q       <= 1'b0;
         vblank_q       <= 1'b0;
         frame_cnt      <= '0;
         scan_pend      <= 1'b0;
         idx            <= '0;
         sum            <= '0;
         baseline       <= '0;
         baseline_valid <= 1'b0;
         din_q          <= 8'hFF;
         addr_q         <= '0;
         ram_read_q     <= 1'b0;
         pause_req_q    <= 1'b0;
         upload_req_q   <= 1'b0;
`ifdef HS_DUMP_TIMEOUT_EN
         to_cnt         <= '0;
         no_ram         <= 1'b0;
`endif
      end else begin
         upload_q     <= bus.ioctl_upload;
         vblank_q     <= vblank;
         upload_req_q <= 1'b0;

         if (!autosave) begin
            frame_cnt <= '0;
            scan_pend <= 1'b0;
         end else if (scan_due) begin
            if (scan_start) begin
               frame_cnt <= '0;
               scan_pend <= 1'b0;
            end else begin
               scan_pend <= 1'b1;
            end
         end else if (vblank_rise) begin
            frame_cnt <= frame_cnt + 1'b1;
         end

         // Baseline already holds the last completed scan sum, so leaving an upload keeps it.
         if (in_upload && !bus.ioctl_upload) begin
            pause_req_q <= 1'b0;
            ram_read_q  <= 1'b0;
            state       <= IDLE;
         end else if (in_scan && upload_rise) begin
            ram_read_q <= 1'b0;
            state      <= paused ? UP_WAIT : UP_PAUSE;
`ifdef HS_DUMP_TIMEOUT_EN
            to_cnt     <= '0;
            no_ram     <= 1'b0;
`endif
         end else begin
            case (state)
               IDLE: begin
                  if (upload_rise) begin
                     pause_req_q <= 1'b1;
                     state       <= UP_PAUSE;
`ifdef HS_DUMP_TIMEOUT_EN
                     to_cnt      <= '0;
                     no_ram      <= 1'b0;
`endif
                  end else if (scan_start) begin
                     pause_req_q <= 1'b1;
                     state       <= SC_PAUSE;
`ifdef HS_DUMP_TIMEOUT_EN
                     to_cnt      <= '0;
`endif
                  end
               end
               UP_PAUSE: begin
                  if (paused) begin
                     state <= UP_WAIT;
`ifdef HS_DUMP_TIMEOUT_EN
                  end else if (to_hit) begin
                     no_ram <= 1'b1;
                     state  <= UP_WAIT;
                  end else begin
                     to_cnt <= to_cnt + 16'd1;
`endif
                  end
               end
               UP_WAIT: begin
                  if (bus.ioctl_rd) begin
                     if (rd_in_region) begin
                        addr_q     <= REGION_BASE + bus.ioctl_addr[RAM_AW-1:0];
                        ram_read_q <= 1'b1;
                        state      <= UP_FETCH;
                     end else begin
                        din_q <= 8'hFF;
                     end
                  end
               end
               UP_FETCH: state <= UP_LATCH;
               UP_LATCH: begin
                  din_q      <= bus.ram_data;
                  ram_read_q <= 1'b0;
                  state      <= UP_WAIT;
               end
               SC_PAUSE: begin
                  if (paused) begin
                     idx        <= '0;
                     sum        <= '0;
                     addr_q     <= REGION_BASE;
                     ram_read_q <= 1'b1;
                     state      <= SC_READ;
`ifdef HS_DUMP_TIMEOUT_EN
                  end else if (to_hit) begin
                     pause_req_q <= 1'b0;
                     state       <= IDLE;
                  end else begin
                     to_cnt <= to_cnt + 16'd1;
`endif
                  end
               end
               SC_READ: state <= SC_ACC;
               SC_ACC: begin
                  sum <= sum_next;
                  if (idx == IDX_LAST) begin
                     ram_read_q <= 1'b0;
                     state      <= SC_CMP;
                  end else begin
                     idx    <= idx + 1'b1;
                     addr_q <= REGION_BASE + idx + 1'b1;
                     state  <= SC_READ;
                  end
               end
               SC_CMP: begin
                  if (!baseline_valid) begin
                     baseline       <= sum;
                     baseline_valid <= 1'b1;
                  end else if (sum != baseline) begin
                     upload_req_q <= ~bus.ioctl_upload;
                     baseline     <= sum;
                  end
                  pause_req_q <= 1'b0;
                  state       <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.ioctl_din   = din_q;
   assign bus.ram_address = addr_q;
   assign bus.ram_read    = ram_read_q;
   assign pause_req       = pause_req_q;
   assign upload_req      = upload_req_q;
   assign busy            = (state != IDLE);
endmodule

// File: tb/tb_hiscore_dumper.sv
// tb/tb_hiscore_dumper.sv - directed bench for hiscore_dumper upload, autosave, pre-emption and reset
module tb_hiscore_dumper;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n, paused, autosave, vblank;
   logic pause_req, upload_req, busy;
   int   checks = 0;
   int   failures = 0;
   int   pulses = 0;
   int   viol = 0;
   int   dur, drops;
   logic [7:0] mem [0:4095];

   hiscore_dumper_if #(.RAM_AW(12)) bus();

   hiscore_dumper #(
      .RAM_AW(12), .REGION_BASE(12'h100), .REGION_LEN(64), .SCAN_FRAMES(2)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus), .paused(paused),
      .pause_req(pause_req), .autosave(autosave), .vblank(vblank),
      .upload_req(upload_req), .busy(busy)
   );

   always @(posedge clk) bus.ram_data <= mem[bus.ram_address];

   always @(posedge clk) begin
      if (upload_req) pulses <= pulses + 1;
      if (upload_req && bus.ioctl_upload) viol <= viol + 1;
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic vb();
      vblank = 1'b1; tick();
      vblank = 1'b0; tick();
   endtask

   task automatic hread(input logic [24:0] a);
      bus.ioctl_addr = a; bus.ioctl_rd = 1'b1; tick();
      bus.ioctl_rd = 1'b0;
   endtask

   task automatic run_scan(output int d);
      paused = 1'b1; tick();
      d = 0;
      while (busy && d < 400) begin tick(); d++; end
      paused = 1'b0; tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0; paused = 1'b0; autosave = 1'b0; vblank = 1'b0;
      bus.ioctl_upload = 1'b0; bus.ioctl_rd = 1'b0; bus.ioctl_addr = '0;
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      for (int i = 0; i < 64; i++) mem[256 + i] = 8'(i);
      tick(3);
      check("rst_pause_req", 32'(pause_req), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_din", 32'(bus.ioctl_din), 32'hFF);
      check("rst_upload_req", 32'(upload_req), 0);
      check("rst_ram_read", 32'(bus.ram_read), 0);
      reset_n = 1'b1;

      bus.ioctl_upload = 1'b1; tick();
      check("up_pause_req", 32'(pause_req), 1);
      check("up_busy", 32'(busy), 1);
      tick(4); paused = 1'b1; tick();
      check("up_wait_ram_read", 32'(bus.ram_read), 0);
      hread(25'h05);
      check("up_ram_address", 32'(bus.ram_address), 32'h105);
      check("up_ram_read", 32'(bus.ram_read), 1);
      tick(2);
      check("up_din_05", 32'(bus.ioctl_din), 32'h05);
      check("up_ram_read_drop", 32'(bus.ram_read), 0);
      hread(25'h3F); tick(2);
      check("up_din_3f", 32'(bus.ioctl_din), 32'h3F);
      hread(25'h40);
      check("up_din_oob", 32'(bus.ioctl_din), 32'hFF);
      check("up_oob_ram_read", 32'(bus.ram_read), 0);
      tick();
      check("up_oob_ram_read2", 32'(bus.ram_read), 0);
      bus.ioctl_upload = 1'b0; paused = 1'b0; tick();
      check("up_end_pause_req", 32'(pause_req), 0);
      check("up_end_busy", 32'(busy), 0);

      autosave = 1'b1;
      vb();
      check("as_count1_idle", 32'(busy), 0);
      vb();
      check("as_scan1_trig", 32'(pause_req), 1);
      run_scan(dur);
      check("as_scan1_dur", dur, 129);
      check("as_scan1_pulses", pulses, 0);
      check("as_scan1_pause_drop", 32'(pause_req), 0);
      vb(); vb();
      check("as_scan2_trig", 32'(pause_req), 1);
      run_scan(dur);
      check("as_scan2_dur", dur, 129);
      check("as_scan2_pulses", pulses, 0);
      mem[12'h100] = 8'h99;
      vb(); vb();
      run_scan(dur);
      check("as_scan3_dur", dur, 129);
      check("as_scan3_pulses", pulses, 1);

      vb();
      autosave = 1'b0; tick(); autosave = 1'b1;
      vb();
      check("as_clear_no_scan", 32'(busy), 0);
      vb();
      check("pre_trig", 32'(pause_req), 1);

      drops = 0;
      paused = 1'b1; tick();
      for (int i = 0; i < 20; i++) begin tick(); if (!pause_req) drops++; end
      bus.ioctl_upload = 1'b1; tick();
      if (!pause_req) drops++;
      check("pre_busy", 32'(busy), 1);
      check("pre_ram_read", 32'(bus.ram_read), 0);
      hread(25'h00);
      if (!pause_req) drops++;
      check("pre_ram_address", 32'(bus.ram_address), 32'h100);
      tick(2);
      if (!pause_req) drops++;
      check("pre_din", 32'(bus.ioctl_din), 32'h99);
      bus.ioctl_upload = 1'b0; paused = 1'b0; tick();
      check("pre_no_drop", drops, 0);
      check("pre_pulses", pulses, 1);
      check("pre_end_pause_req", 32'(pause_req), 0);
      vb(); vb();
      run_scan(dur);
      check("pre_baseline_kept", pulses, 1);

      vb();
      vblank = 1'b1; bus.ioctl_upload = 1'b1; tick();
      vblank = 1'b0;
      check("col_busy", 32'(busy), 1);
      check("col_pause_req", 32'(pause_req), 1);
      paused = 1'b1; tick();
      hread(25'h01); tick(2);
      check("col_read", 32'(bus.ioctl_din), 32'h01);
      bus.ioctl_upload = 1'b0; paused = 1'b0; tick();
      check("col_idle_pause_req", 32'(pause_req), 0);
      check("col_idle_busy", 32'(busy), 0);
      tick();
      check("col_scan_start", 32'(pause_req), 1);
      run_scan(dur);
      check("col_scan_dur", dur, 129);
      check("col_scan_pulses", pulses, 1);

      vb(); vb();
      paused = 1'b1; tick(10);
      reset_n = 1'b0; tick();
      check("rstmid_pause_req", 32'(pause_req), 0);
      check("rstmid_busy", 32'(busy), 0);
      tick(2);
      check("rstmid_din", 32'(bus.ioctl_din), 32'hFF);
      check("rstmid_upload_req", 32'(upload_req), 0);
      check("rstmid_ram_read", 32'(bus.ram_read), 0);
      reset_n = 1'b1; paused = 1'b0; tick();
      vb(); vb();
      check("rst_rescan_trig", 32'(pause_req), 1);
      run_scan(dur);
      check("rst_rescan_no_pulse", pulses, 1);
      check("upload_req_during_upload", viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/hiscore_dumper.md
Name: hiscore_dumper

Overview:
- Read-side companion to the hiscore restore path. It services HPS upload requests (ioctl_upload/ioctl_rd) by pausing the CPU, reading the hiscore region from game work RAM and presenting bytes on ioctl_din.
- When autosave is on, it also checksums the region every N frames and pulses upload_req when the scores have changed.
- It sits beside the hiscore block, on the same RAM port mux, in the clk_sys domain.

Parameters:
- RAM_AW, 12, width of the game RAM address.
- REGION_BASE, 12'h000, first RAM address of the hiscore region.
- REGION_LEN, 64, region length in bytes (1..2^RAM_AW).
- SCAN_FRAMES, 60, number of vblank rising edges between autosave scans (>=1).
- TIMEOUT, 65535, pause-acknowledge timeout in clocks (used only with the optional feature).

Ports:
- clk  in  1  system clock (clk_sys).
- reset_n  in  1  synchronous, active-low reset.
- ioctl_upload  in  1  HPS upload window active.
- ioctl_rd  in  1  one-cycle byte read strobe from HPS.
- ioctl_addr  in  25  byte offset requested by HPS.
- ioctl_din  out  8  byte returned to HPS.
- ram_address  out  RAM_AW  game RAM address.
- ram_data  in  8  game RAM read data; synchronous RAM, 1-cycle latency.
- ram_read  out  1  RAM port claim; the mux selects this block while it is high.
- paused  in  1  CPU-halted acknowledge.
- pause_req  out  1  request CPU halt.
- autosave  in  1  enables periodic change scans.
- vblank  in  1  vertical blank, already in the clk domain.
- upload_req  out  1  one-cycle pulse requesting an HPS upload.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset_n=0 at a clk edge): state IDLE, all outputs 0, ioctl_din=8'hFF, frame counter 0, baseline_valid=0, baseline 0. A reset mid-operation abandons the operation immediately and drops pause_req on the same edge.
- Edge detectors: registered ioctl_upload and vblank, rising edges only.
- States: IDLE, UP_PAUSE, UP_WAIT, UP_FETCH, UP_LATCH, SC_PAUSE, SC_READ, SC_ACC, SC_CMP.
- Upload path:
  - ioctl_upload rise -> UP_PAUSE; pause_req=1.
  - When paused=1 -> UP_WAIT.
  - On ioctl_rd in UP_WAIT, latch ioctl_addr as A:
    - If A < REGION_LEN: ram_address = REGION_BASE + A (mod 2^RAM_AW), ram_read=1 -> UP_FETCH -> UP_LATCH, where ioctl_din <= ram_data -> UP_WAIT. ioctl_din is valid 2 clocks after ioctl_rd.
    - If A >= REGION_LEN: ioctl_din=8'hFF on the next clock, no RAM access.
  - An ioctl_rd arriving in UP_FETCH or UP_LATCH is a protocol error and is ignored.
  - ioctl_upload fall in any UP_* state -> baseline <= last completed scan sum if one exists, else unchanged; baseline_valid unchanged; pause_req=0; ram_read=0; -> IDLE.
- Frame counter: increments on vblank rise while autosave=1; resets to 0 when autosave=0.
- Scan path:
  - Trigger when the counter reaches SCAN_FRAMES-1 in IDLE: counter <- 0 -> SC_PAUSE, pause_req=1.
  - If not in IDLE at terminal count, the counter holds at SCAN_FRAMES-1 and the scan starts on the first IDLE cycle.
  - On paused -> SC_READ: index i=0..REGION_LEN-1, one byte per 2 clocks (issue, accumulate).
  - Accumulator: 16-bit, sum <= {sum[14:0],sum[15]} + {8'h00,byte}, mod 2^16, initialised to 0.
  - After the last byte -> SC_CMP:
    - If baseline_valid=0: baseline<=sum, baseline_valid<=1, no pulse.
    - Else if sum!=baseline: upload_req=1 for exactly one clock, baseline<=sum.
    - Then pause_req=0 -> IDLE.
  - Scan duration after paused: 2*REGION_LEN+1 clocks.
- Pre-emption: ioctl_upload rise during any SC_* state aborts the scan (no compare, sum discarded). The next state is UP_PAUSE, or UP_WAIT if paused=1; pause_req stays high continuously.
- Simultaneous events: ioctl_upload rise and scan trigger on the same clock -> upload wins and the counter holds.
- upload_req is never asserted while ioctl_upload=1.

Optional Feature:
- HS_DUMP_TIMEOUT_EN defined: a 16-bit counter runs in UP_PAUSE/SC_PAUSE.
  - SC_PAUSE reaching TIMEOUT without paused -> pause_req=0 -> IDLE, no compare.
  - UP_PAUSE reaching TIMEOUT -> UP_WAIT with RAM access disabled; every ioctl_rd returns 8'hFF.
- Undefined: the PAUSE states wait for paused indefinitely, and the counter logic is absent.

Test Plan:
- Reset: hold reset_n=0 3 clocks mid-scan -> pause_req=0, busy=0, ioctl_din=8'hFF, upload_req=0 on the next clock.
- Upload, REGION_BASE=12'h100, RAM[0x100..0x13F]=0x00..0x3F: raise ioctl_upload, paused after 5 clocks, ioctl_rd with addr 0x05 -> ram_address=0x105, ioctl_din=0x05 two clocks after ioctl_rd. addr 0x40 -> ioctl_din=0xFF, ram_read stays 0.
- Autosave, SCAN_FRAMES=2: 2 vblanks -> first scan sets baseline, no pulse. Unchanged RAM, 2 more vblanks -> no pulse. Write RAM[0x100]=0x99, 2 vblanks -> exactly one upload_req pulse. Each scan lasts 129 clocks after paused.
- Pre-emption: raise ioctl_upload at scan byte 10 -> no upload_req, pause_req never drops, next ioctl_rd is served normally, baseline unchanged.
- Collision: ioctl_upload rise on the same clock as the scan trigger -> state UP_PAUSE. The scan runs right after ioctl_upload falls.
- HS_DUMP_TIMEOUT_EN with TIMEOUT=100 and paused tied 0: scan -> pause_req drops at clock 100, no pulse. Upload -> ioctl_rd returns 0xFF, ram_read stays 0.
